tc_countdown_timer: RTL and testbench
=====================================

// Module: tc_countdown_timer
// PURPOSE
//   Loadable down-counter/timer, the decrementing counterpart of the TC up-counter.
//   Software or an FSM loads a start value, starts it, and is notified on expiry.
//   Notification is a 1-cycle tick plus a sticky done flag held until ack.
//   Used for delay loops, watchdogs and periodic event generation in TC designs.
// PARAMETERS
//   BIT_WIDTH  8  width of counter, reload register and in/out buses
//   count      1  decrement step per enabled cycle; must be >= 1
// PORTS
//   clk       in   1          single clock, rising edge
//   rst       in   1          asynchronous, active-low reset
//   load      in   1          capture in into value and reload registers; go to IDLE
//   in        in   BIT_WIDTH  load value
//   start     in   1          IDLE->RUN if value != 0
//   stop      in   1          RUN->IDLE; value is held
//   periodic  in   1          1: reload on expiry and keep running; 0: one-shot
//   ack       in   1          clears done
//   out       out  BIT_WIDTH  current counter value (registered)
//   running   out  1          1 while state == RUN
//   tick      out  1          1-cycle pulse on the cycle after expiry
//   done      out  1          sticky expiry flag
// BEHAVIOUR
//   - Reset (rst=0, async): value=0, reload=0, state=IDLE, tick=0, done=0.
//     All outputs are 0 while reset is asserted.
//   - States: IDLE (value held), RUN (value decrements by count per clk).
//   - Command priority per edge: load > stop > start. Lower-priority commands in
//     the same cycle are ignored.
//   - load: value<=in, reload<=in, state<=IDLE. done is not affected.
//     A load in RUN aborts the count with no tick.
//   - start in IDLE with value==0: ignored; state stays IDLE.
//     start in RUN: no effect.
//   - RUN, value > count: value <= value - count.
//   - RUN, value <= count: expiry. The value never wraps below zero.
//       periodic=1: value<=reload, stay RUN.
//                   If reload==0, value<=0 and state<=IDLE.
//       periodic=0: value<=0, state<=IDLE.
//       tick=1 for exactly the next cycle; done<=1.
//   - periodic is sampled only at the expiry edge and may change freely otherwise.
//   - ack clears done on the next edge. If ack and expiry coincide, set wins
//     and done stays 1.
//   - Latency: with value=N loaded, count=1 and start at edge 0, expiry occurs at
//     edge N. tick and done are visible after edge N, and out reads 0 (one-shot).
//   - out always equals the value register. running equals (state==RUN).
//   - Width: subtraction is BIT_WIDTH wide. The compare value<=count replaces any
//     underflow.
//   - Reset mid-run: immediate return to the reset values; no tick is emitted.
// STRUCTURE
//   - Shared package tc_pkg:
//       timer state enum {TMR_IDLE, TMR_RUN}
//       localparam for the state encoding width
//   - One natural sub-module: tc_countdown_core, holding value/reload registers,
//     decrement and expiry compare. This top adds the FSM, done/ack and tick.
//   - No other hierarchy. All state lives in flops reset by the async rst.
// TESTING
//   1. Reset: rst=0 with load=1, in=8'h55 -> out=0, running=0, tick=0, done=0.
//   2. One-shot: load 5, start, periodic=0 -> out 5,4,3,2,1,0.
//      tick high exactly 1 cycle at out=0; running=0; done=1 until ack.
//   3. Periodic: load 3, start, periodic=1 -> out 3,2,1,3,2,1,3...
//      tick every 3rd cycle; running stays 1.
//   4. Step and edge cases:
//      - count=2, load 5: out 5,3,1, then expiry with no wrap to 8'hFF.
//      - start with value 0: running stays 0.
//   5. Priority: load=1, stop=1 and start=1 in the same cycle while running ->
//      value=in, IDLE, no tick.
//      stop at out=4 holds 4; a later start resumes from 3.
//   6. ack on the expiry cycle -> done remains 1. Next ack alone -> done=0.
//      Async rst mid-run -> immediate zeros with no tick.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared TC timer definitions: FSM state encoding for the countdown timer.
package tc_pkg;
  localparam int TMR_SW = 1;

  typedef enum logic [TMR_SW-1:0] {
    TMR_IDLE = 1'b0,
    TMR_RUN  = 1'b1
  } tmr_state_e;
endpackage

// File: rtl/tc_countdown_timer_if.sv
// Command/status bundle between a controller and tc_countdown_timer.
interface tc_countdown_timer_if #(
    parameter int BIT_WIDTH = 8
);
    logic                 load;
    logic [BIT_WIDTH-1:0] in;
    logic                 start;
    logic                 stop;
    logic                 periodic;
    logic                 ack;
    logic [BIT_WIDTH-1:0] out;
    logic                 running;
    logic                 tick;
    logic                 done;

    modport master (
        output load, in, start, stop, periodic, ack,
        input  out, running, tick, done
    );

    modport slave (
        input  load, in, start, stop, periodic, ack,
        output out, running, tick, done
    );
endinterface

// File: rtl/tc_countdown_core.sv
// Value/reload registers with saturating decrement and expiry detect.
module tc_countdown_core #(
    parameter int BIT_WIDTH = 8,
    parameter int count     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [BIT_WIDTH-1:0] ld_val,
    input  logic                 step,
    input  logic                 periodic,
    output logic [BIT_WIDTH-1:0] value,
    output logic                 reload_zero,
    output logic                 expire
);
    localparam logic [BIT_WIDTH-1:0] STEP = BIT_WIDTH'(count);

    logic [BIT_WIDTH-1:0] reload;

    // The compare stands in for a borrow: the value never wraps below zero.
    assign expire      = step && (value <= STEP);
    assign reload_zero = (reload == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value  <= '0;
            reload <= '0;
        end else if (load) begin
            value  <= ld_val;
            reload <= ld_val;
        end else if (expire) begin
            value  <= periodic ? reload : '0;
        end else if (step) begin
            value  <= value - STEP;
        end
    end
endmodule

// File: rtl/tc_countdown_timer.sv
// Loadable countdown timer: IDLE/RUN FSM, 1-cycle expiry tick, sticky done until ack.
module tc_countdown_timer
    import tc_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int count     = 1
) (
    input logic                 clk,
    input logic                 rst,
    tc_countdown_timer_if.slave tif
);
    localparam logic [TMR_SW-1:0] S_IDLE = TMR_IDLE;
    localparam logic [TMR_SW-1:0] S_RUN  = TMR_RUN;

    logic [TMR_SW-1:0]    state;
    logic [BIT_WIDTH-1:0] value;
    logic                 running;
    logic                 step;
    logic                 expire;
    logic                 reload_zero;
    logic                 tick_q;
    logic                 done_q;

    assign running = (state == S_RUN);
    // load and stop both pre-empt the decrement, so a load in RUN never ticks.
    assign step    = running && !tif.load && !tif.stop;

    tc_countdown_core #(
        .BIT_WIDTH(BIT_WIDTH),
        .count    (count)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .load       (tif.load),
        .ld_val     (tif.in),
        .step       (step),
        .periodic   (tif.periodic),
        .value      (value),
        .reload_zero(reload_zero),
        .expire     (expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else if (tif.load || tif.stop) begin
            state <= S_IDLE;
        end else if (running) begin
            if (expire && !(tif.periodic && !reload_zero))
                state <= S_IDLE;
        end else if (tif.start && value != '0) begin
            state <= S_RUN;
        end
    end

    // Expiry sets done even when ack arrives on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            tick_q <= expire;
            done_q <= expire || (done_q && !tif.ack);
        end
    end

    assign tif.out     = value;
    assign tif.running = running;
    assign tif.tick    = tick_q;
    assign tif.done    = done_q;
endmodule

// File: tb/tb_tc_countdown_timer.sv
// Scoreboard bench for tc_countdown_timer: directed vectors, queued expectations, negedge monitor.
module tb_tc_countdown_timer;
    typedef struct packed {
        logic [7:0] out;
        logic       running;
        logic       tick;
        logic       done;
    } obs_t;

    typedef struct {
        int    u;
        obs_t  e;
        string nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    exp_t x;
    obs_t a;
    obs_t obs0, obs1;

    always #5 clk = ~clk;

    tc_countdown_timer_if #(.BIT_WIDTH(8)) u0_if ();
    tc_countdown_timer_if #(.BIT_WIDTH(8)) u1_if ();

    tc_countdown_timer #(.BIT_WIDTH(8), .count(1)) dut0 (.clk(clk), .rst(rst), .tif(u0_if));
    tc_countdown_timer #(.BIT_WIDTH(8), .count(2)) dut1 (.clk(clk), .rst(rst), .tif(u1_if));

    assign obs0 = {u0_if.out, u0_if.running, u0_if.tick, u0_if.done};
    assign obs1 = {u1_if.out, u1_if.running, u1_if.tick, u1_if.done};

    task automatic drive(input int u, input logic ld, input logic [7:0] din,
                         input logic st, input logic sp, input logic per, input logic ak);
        if (u == 0) begin
            u0_if.load = ld; u0_if.in = din; u0_if.start = st;
            u0_if.stop = sp; u0_if.periodic = per; u0_if.ack = ak;
        end else begin
            u1_if.load = ld; u1_if.in = din; u1_if.start = st;
            u1_if.stop = sp; u1_if.periodic = per; u1_if.ack = ak;
        end
    endtask

    task automatic expect_obs(input int u, input logic [7:0] eo, input logic er,
                              input logic et, input logic ed, input string nm);
        exp_t e;
        e.u  = u;
        e.e  = {eo, er, et, ed};
        e.nm = nm;
        q.push_back(e);
    endtask

    // Apply inputs for one edge, then queue the state expected after that edge.
    task automatic cyc(input int u, input logic ld, input logic [7:0] din, input logic st,
                       input logic sp, input logic per, input logic ak,
                       input logic [7:0] eo, input logic er, input logic et, input logic ed,
                       input string nm);
        drive(u, ld, din, st, sp, per, ak);
        @(posedge clk);
        #1;
        expect_obs(u, eo, er, et, ed, nm);
        drive(u, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                x = q.pop_front();
                a = (x.u == 0) ? obs0 : obs1;
                checks++;
                if (a !== x.e) begin
                    errors++;
                    $display("FAIL %s: got out=%h run=%b tick=%b done=%b, want out=%h run=%b tick=%b done=%b",
                             x.nm, a.out, a.running, a.tick, a.done,
                             x.e.out, x.e.running, x.e.tick, x.e.done);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        drive(0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        expect_obs(0, 8'h00, 0, 0, 0, "reset0");
        expect_obs(1, 8'h00, 0, 0, 0, "reset1");
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;

        // one-shot, load 5
        cyc(0, 1, 8'd5, 0, 0, 0, 0, 8'd5, 0, 0, 0, "os_load");
        cyc(0, 0, 8'd0, 1, 0, 0, 0, 8'd5, 1, 0, 0, "os_start");
        cyc(0, 0, 8'd0, 0, 0, 0, 0, 8'd4, 1, 0, 0, "os_4");
        cyc(0, 0, 8'd0, 0, 0, 0, 0, 8'd3, 1, 0, 0, "os_3");
        cyc(0, 0, 8'd0, 0, 0, 0, 0, 8'd2, 1, 0, 0, "os_2");
        cyc(0, 0, 8'd0, 0, 0, 0, 0, 8'd1, 1, 0, 0, "os_1");
        cyc(0, 0, 8'd0, 0, 0, 0, 0, 8'd0, 0, 1, 1, "os_expire");
        cyc(0, 0, 8'd0, 0, 0, 0, 0, 8'd0, 0, 0, 1, "os_done_held");
        cyc(0, 0, 8'd0, 0, 0, 0, 1, 8'd0, 0, 0, 0, "os_ack");

        // periodic, load 3
        cyc(0, 1, 8'd3, 0, 0, 1, 0, 8'd3, 0, 0, 0, "per_load");
        cyc(0, 0, 8'd0, 1, 0, 1, 0, 8'd3, 1, 0, 0, "per_start");
        cyc(0, 0, 8'd0, 0, 0, 1, 0, 8'd2, 1, 0, 0, "per_2a");
        cyc(0, 0, 8'd0, 0, 0, 1, 0, 8'd1, 1, 0, 0, "per_1a");
        cyc(0, 0, 8'd0, 0, 0, 1, 0, 8'd3, 1, 1, 1, "per_reload_a");
        cyc(0, 0, 8'd0, 0, 0, 1, 0, 8'd2, 1, 0, 1, "per_2b");
        cyc(0, 0, 8'd0, 0, 0, 1, 0, 8'd1, 1, 0, 1, "per_1b");
        cyc(0, 0, 8'd0, 0, 0, 1, 0, 8'd3, 1, 1, 1, "per_reload_b");
        cyc(0, 0, 8'd0, 0, 1, 1, 0, 8'd3, 0, 0, 1, "per_stop");
        cyc(0, 0, 8'd0, 0, 0, 0, 1, 8'd3, 0, 0, 0, "per_ack");

        // stop/resume and command priority
        cyc(0, 1, 8'd6, 0, 0, 0, 0, 8'd6, 0, 0, 0, "pri_load");
        cyc(0, 0, 8'd0, 1, 0, 0, 0, 8'd6, 1, 0, 0, "pri_start");
        cyc(0, 0, 8'd0, 0, 0, 0, 0, 8'd5, 1, 0, 0, "pri_5");
        cyc(0, 0, 8'd0, 0, 0, 0, 0, 8'd4, 1, 0, 0, "pri_4");
        cyc(0, 0, 8'd0, 0, 1, 0, 0, 8'd4, 0, 0, 0, "stop_hold4");
        cyc(0, 0, 8'd0, 1, 0, 0, 0, 8'd4, 1, 0, 0, "restart");
        cyc(0, 0, 8'd0, 0, 0, 0, 0, 8'd3, 1, 0, 0, "resume_3");
        cyc(0, 1, 8'd9, 1, 1, 0, 0, 8'd9, 0, 0, 0, "load_stop_start");
        cyc(0, 0, 8'd0, 0, 0, 0, 0, 8'd9, 0, 0, 0, "abort_no_tick");

        // start with value 0 is ignored
        cyc(0, 1, 8'd0, 0, 0, 0, 0, 8'd0, 0, 0, 0, "zero_load");
        cyc(0, 0, 8'd0, 1, 0, 0, 0, 8'd0, 0, 0, 0, "zero_start");

        // ack coinciding with expiry
        cyc(0, 1, 8'd2, 0, 0, 0, 0, 8'd2, 0, 0, 0, "ack_load");
        cyc(0, 0, 8'd0, 1, 0, 0, 0, 8'd2, 1, 0, 0, "ack_start");
        cyc(0, 0, 8'd0, 0, 0, 0, 0, 8'd1, 1, 0, 0, "ack_1");
        cyc(0, 0, 8'd0, 0, 0, 0, 1, 8'd0, 0, 1, 1, "ack_vs_set");
        cyc(0, 0, 8'd0, 0, 0, 0, 0, 8'd0, 0, 0, 1, "ack_set_held");
        cyc(0, 0, 8'd0, 0, 0, 0, 1, 8'd0, 0, 0, 0, "ack_clear");

        // count=2: 5,3,1 then expiry with no wrap
        cyc(1, 1, 8'd5, 0, 0, 0, 0, 8'd5, 0, 0, 0, "c2_load");
        cyc(1, 0, 8'd0, 1, 0, 0, 0, 8'd5, 1, 0, 0, "c2_start");
        cyc(1, 0, 8'd0, 0, 0, 0, 0, 8'd3, 1, 0, 0, "c2_3");
        cyc(1, 0, 8'd0, 0, 0, 0, 0, 8'd1, 1, 0, 0, "c2_1");
        cyc(1, 0, 8'd0, 0, 0, 0, 0, 8'd0, 0, 1, 1, "c2_nowrap");
        cyc(1, 0, 8'd0, 0, 0, 0, 0, 8'd0, 0, 0, 1, "c2_after");

        // asynchronous reset mid-run
        cyc(0, 1, 8'd4, 0, 0, 0, 0, 8'd4, 0, 0, 0, "ar_load");
        cyc(0, 0, 8'd0, 1, 0, 0, 0, 8'd4, 1, 0, 0, "ar_start");
        cyc(0, 0, 8'd0, 0, 0, 0, 0, 8'd3, 1, 0, 0, "ar_3");
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        expect_obs(0, 8'h00, 0, 0, 0, "async_rst0");
        expect_obs(1, 8'h00, 0, 0, 0, "async_rst1");
        @(posedge clk);
        #1;
        expect_obs(0, 8'h00, 0, 0, 0, "rst_held");
        rst = 1'b1;
        cyc(0, 0, 8'd0, 0, 0, 0, 0, 8'd0, 0, 0, 0, "post_rst_no_tick");

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
